// File: rtl/bmm_result_accumulator.sv
// bmm_result_accumulator
// Sums each group of K consecutive signed product terms into one C[b][i][j]
// element and presents it on a single-entry, backpressured output register
// tagged with batch/row/column indices. Element order: column innermost.
module bmm_result_accumulator #(
    parameter int K     = 4,
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int BATCH = 2,
    parameter int ACC_W = 40,
    localparam int KW   = (K     > 1) ? $clog2(K)     : 1,
    localparam int MW   = (M     > 1) ? $clog2(M)     : 1,
    localparam int NW   = (N     > 1) ? $clog2(N)     : 1,
    localparam int BW   = (BATCH > 1) ? $clog2(BATCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    valid_in,
    input  logic signed [31:0]      data_in,
    output logic                    ready_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic signed [ACC_W-1:0] result,
    output logic [BW-1:0]           batch_idx,
    output logic [MW-1:0]           row_idx,
    output logic [NW-1:0]           col_idx,
    output logic                    last_out
);

    // Accumulation state.
    logic signed [ACC_W-1:0] r_acc;
    logic [KW-1:0]           r_k_cnt;

    // Element position counters (position of the element being built).
    logic [BW-1:0]           r_batch;
    logic [MW-1:0]           r_row;
    logic [NW-1:0]           r_col;

    // Output slot.
    logic                    r_valid_out;
    logic signed [ACC_W-1:0] r_result;
    logic [BW-1:0]           r_batch_idx;
    logic [MW-1:0]           r_row_idx;
    logic [NW-1:0]           r_col_idx;
    logic                    r_last_out;

    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_final;
    logic                    w_accept;
    logic                    w_last_elem;

    // A signed size cast sign-extends the 32-bit term to the accumulator width.
    assign w_term      = ACC_W'(data_in);
    assign w_sum       = r_acc + w_term;
    assign w_final     = (r_k_cnt == KW'(K - 1));
    assign w_last_elem = (r_row == MW'(M - 1)) && (r_col == NW'(N - 1));

    // NOTE: ready_in is a combinational function of ready_out and clear, so
    // the completing term and a draining consumer can meet in the same cycle
    // without a bubble; only a completing term into a full, stalled slot waits.
    assign ready_in = clear || !(w_final && r_valid_out && !ready_out);
    assign w_accept = valid_in && ready_in;

    // Accumulate terms, complete elements, advance element counters, manage output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_k_cnt     <= '0;
            r_batch     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_batch_idx <= '0;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_last_out  <= 1'b0;
        end else if (clear) begin
            // A term presented alongside clear is consumed and discarded.
            r_acc       <= '0;
            r_k_cnt     <= '0;
            r_batch     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_batch_idx <= '0;
            r_row_idx   <= '0;
            r_col_idx   <= '0;
            r_last_out  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the drain below be overridden
            // by a same-cycle load later in this block (last assignment wins),
            // and every read sees the pre-edge value of each register.
            if (r_valid_out && ready_out) begin
                r_valid_out <= 1'b0;
            end

            if (w_accept) begin
                if (w_final) begin
                    r_result    <= w_sum;
                    r_valid_out <= 1'b1;
                    r_batch_idx <= r_batch;
                    r_row_idx   <= r_row;
                    r_col_idx   <= r_col;
                    r_last_out  <= w_last_elem;
                    r_acc       <= '0;
                    r_k_cnt     <= '0;

                    if (r_col == NW'(N - 1)) begin
                        r_col <= '0;
                        if (r_row == MW'(M - 1)) begin
                            r_row <= '0;
                            if (r_batch == BW'(BATCH - 1)) begin
                                r_batch <= '0;
                            end else begin
                                r_batch <= r_batch + BW'(1);
                            end
                        end else begin
                            r_row <= r_row + MW'(1);
                        end
                    end else begin
                        r_col <= r_col + NW'(1);
                    end
                end else begin
                    r_acc   <= w_sum;
                    r_k_cnt <= r_k_cnt + KW'(1);
                end
            end
        end
    end

    assign valid_out = r_valid_out;
    assign result    = r_result;
    assign batch_idx = r_batch_idx;
    assign row_idx   = r_row_idx;
    assign col_idx   = r_col_idx;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_bmm_result_accumulator.sv
// Testbench for bmm_result_accumulator: directed scenarios followed by random
// traffic, all checked against a behavioural model built from term counts,
// element numbers and a one-entry output slot.
module tb_bmm_result_accumulator;

    localparam int K     = 4;
    localparam int M     = 2;
    localparam int N     = 2;
    localparam int BATCH = 2;
    localparam int ACC_W = 40;
    localparam int BW    = 1;
    localparam int MW    = 1;
    localparam int NW    = 1;
    localparam longint ACC_MASK = (longint'(1) << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             valid_in;
    logic [31:0]      data_in;
    logic             ready_in;
    logic             valid_out;
    logic             ready_out;
    logic [ACC_W-1:0] result;
    logic [BW-1:0]    batch_idx;
    logic [MW-1:0]    row_idx;
    logic [NW-1:0]    col_idx;
    logic             last_out;

    int n_compared;
    int n_mismatched;

    // Behavioural model state.
    longint m_sum;      // running sum of the element under construction
    int     m_cnt;      // terms accepted into that element
    int     m_elem;     // number of elements completed since reset/clear
    bit     m_valid;    // output slot occupied
    longint m_result;
    int     m_batch, m_row, m_col;
    bit     m_last;
    bit     last_ready; // ready_in observed in the most recent step

    bmm_result_accumulator #(
        .K(K), .M(M), .N(N), .BATCH(BATCH), .ACC_W(ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .result    (result),
        .batch_idx (batch_idx),
        .row_idx   (row_idx),
        .col_idx   (col_idx),
        .last_out  (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sum   = 0;
        m_cnt   = 0;
        m_elem  = 0;
        m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".valid_out"}, 64'(valid_out), 64'(m_valid));
        if (m_valid) begin
            check({where, ".result"},    64'(result),    64'(m_result & ACC_MASK));
            check({where, ".batch_idx"}, 64'(batch_idx), 64'(m_batch));
            check({where, ".row_idx"},   64'(row_idx),   64'(m_row));
            check({where, ".col_idx"},   64'(col_idx),   64'(m_col));
            check({where, ".last_out"},  64'(last_out),  64'(m_last));
        end
    endtask

    // One clock cycle: drive on the falling edge, check ready_in, update the
    // model at the rising edge, then check the output slot just after it.
    task automatic step(input bit v, input logic [31:0] d, input bit ro, input bit cl);
        bit exp_ready;
        int e;
        @(negedge clk);
        valid_in  = v;
        data_in   = d;
        ready_out = ro;
        clear     = cl;
        #1;
        exp_ready = cl || !((m_cnt == K - 1) && m_valid && !ro);
        check("ready_in", 64'(ready_in), 64'(exp_ready));
        last_ready = ready_in;
        @(posedge clk);
        if (cl) begin
            model_clear();
        end else begin
            if (m_valid && ro) m_valid = 1'b0;
            if (v && exp_ready) begin
                m_sum = m_sum + longint'($signed(d));
                m_cnt++;
                if (m_cnt == K) begin
                    e        = m_elem;
                    m_result = m_sum;
                    m_col    = e % N;
                    m_row    = (e / N) % M;
                    m_batch  = (e / (N * M)) % BATCH;
                    m_last   = (m_row == M - 1) && (m_col == N - 1);
                    m_valid  = 1'b1;
                    m_elem++;
                    m_sum    = 0;
                    m_cnt    = 0;
                end
            end
        end
        #1;
        check_outputs("step");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        ready_out = 1'b0;
        model_clear();
        #3;
        check("rst.valid_out", 64'(valid_out), 64'd0);
        check("rst.result",    64'(result),    64'd0);
        check("rst.indices",   64'({batch_idx, row_idx, col_idx}), 64'd0);
        check("rst.last_out",  64'(last_out),  64'd0);
        check("rst.ready_in",  64'(ready_in),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Terms 1,2,3,4 repeated: eight elements of 10, then wrap to batch 0.
        for (int e = 0; e < 9; e++) begin
            for (int k = 0; k < K; k++) step(1'b1, 32'(k + 1), 1'b1, 1'b0);
            check("tp1.result", 64'(result),    64'd10);
            check("tp1.batch",  64'(batch_idx), 64'((e / 4) % 2));
            check("tp1.row",    64'(row_idx),   64'((e / 2) % 2));
            check("tp1.col",    64'(col_idx),   64'(e % 2));
            check("tp1.last",   64'(last_out),  64'(e % 4 == 3));
        end

        // Signed extremes.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < K; k++) step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        check("sgn.max", 64'(result), 64'h01_FFFF_FFFC);
        for (int k = 0; k < K; k++) step(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        check("sgn.min", 64'(result), 64'hFE_0000_0000);

        // Backpressure: slot full, next three terms accepted, completing term stalls.
        step(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < K; k++) step(1'b1, 32'(k + 1), 1'b1, 1'b0);
        for (int k = 0; k < K - 1; k++) begin
            step(1'b1, 32'(10 * (k + 1)), 1'b0, 1'b0);
            check("bp.ready_nonfinal", 64'(last_ready), 64'd1);
            check("bp.hold", 64'(result), 64'd10);
        end
        step(1'b1, 32'd40, 1'b0, 1'b0);
        check("bp.ready_stall", 64'(last_ready), 64'd0);
        check("bp.hold_stall",  64'(result),     64'd10);
        step(1'b1, 32'd40, 1'b1, 1'b0);
        check("bp.ready_release", 64'(last_ready), 64'd1);
        check("bp.valid2",  64'(valid_out), 64'd1);
        check("bp.result2", 64'(result),    64'd100);
        check("bp.col2",    64'(col_idx),   64'd1);

        // clear mid-element with a term present.
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd9, 1'b1, 1'b1);
        check("clr1.valid", 64'(valid_out), 64'd0);
        for (int k = 0; k < K; k++) step(1'b1, 32'd5, 1'b1, 1'b0);
        check("clr1.result", 64'(result), 64'd20);
        check("clr1.idx",    64'({batch_idx, row_idx, col_idx}), 64'd0);

        // clear with an undrained result.
        for (int k = 0; k < K; k++) step(1'b1, 32'd3, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("clr2.pending", 64'(valid_out), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr2.valid", 64'(valid_out), 64'd0);
        for (int k = 0; k < K; k++) step(1'b1, 32'd5, 1'b1, 1'b0);
        check("clr2.result", 64'(result), 64'd20);
        check("clr2.idx",    64'({batch_idx, row_idx, col_idx}), 64'd0);

        // Asynchronous reset mid-element with an output pending.
        step(1'b1, 32'd100, 1'b0, 1'b0);
        step(1'b1, 32'd100, 1'b0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("arst.valid_out", 64'(valid_out), 64'd0);
        check("arst.result",    64'(result),    64'd0);
        check("arst.indices",   64'({batch_idx, row_idx, col_idx}), 64'd0);
        check("arst.last_out",  64'(last_out),  64'd0);
        check("arst.ready_in",  64'(ready_in),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < K; k++) step(1'b1, 32'(k + 2), 1'b1, 1'b0);
        check("arst.post_result", 64'(result), 64'd14);
        check("arst.post_idx",    64'({batch_idx, row_idx, col_idx}), 64'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bmm_result_accumulator.md
# bmm_result_accumulator

Downstream stage of the batched matrix-multiply datapath. It consumes the stream of 32-bit signed partial products (A[b][i][k]·B[b][k][j]) emitted by the multiply stage, one term per accepted beat. It sums each group of K consecutive terms into one output element C[b][i][j]. Each completed element is presented on a single-entry, backpressured output register tagged with its batch, row and column indices.

## Interface
- K, default 4: inner dimension, i.e. terms per output element; range 1..256.
- M, default 4: rows per matrix.
- N, default 4: columns per matrix.
- BATCH, default 2: matrices per batch sequence.
- ACC_W, default 40: accumulator and result width, signed.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous soft clear of counters, accumulator and output.
- valid_in  input  1  a product term is present on data_in.
- data_in  input  32  signed product term.
- ready_in  output  1  the block accepts a term this cycle.
- valid_out  output  1  result holds a completed element.
- ready_out  input  1  the consumer accepts result this cycle.
- result  output  ACC_W  signed C element.
- batch_idx  output  clog2(BATCH) (min 1)  batch index of result.
- row_idx  output  clog2(M) (min 1)  row index of result.
- col_idx  output  clog2(N) (min 1)  column index of result.
- last_out  output  1  result is element (M-1, N-1) of its batch.

## Operation
- Accept rule: a term is accepted when valid_in && ready_in.
- ready_in = clear || !(k_cnt == K-1 && valid_out && !ready_out).
  - Input stalls only on a completing term while the output slot is full and not draining.
  - ready_in is combinational from ready_out and clear.
- Non-final term (k_cnt < K-1):
  - acc <= acc + sign-extended data_in; k_cnt++.
- Final term (k_cnt == K-1):
  - result <= acc + sign-extended data_in; valid_out <= 1.
  - Load the index outputs from the element counters.
  - Clear acc to 0 and k_cnt to 0.
  - Advance the element counters.
- K=1 case: every accepted term is a final term; acc stays 0.
- Element counters advance in column-major-inner order:
  - col wraps N-1→0 and carries into row.
  - row wraps M-1→0 and carries into batch.
  - batch wraps BATCH-1→0; the block then continues with the next sequence, no idle state.
- last_out <= (row == M-1 && col == N-1) when result loads.
- Output register:
  - valid_out drops on ready_out when no new element loads the same cycle.
  - A load in the same cycle as a drain keeps valid_out at 1 with the new data.
  - result and the index outputs hold while valid_out && !ready_out.
- Arithmetic:
  - Two's complement, modulo 2^ACC_W, no saturation.
  - ACC_W ≥ 32+clog2(K) guarantees exact results; the defaults satisfy this.
- clear:
  - Zeroes acc, k_cnt, all element counters, valid_out and last_out.
  - Any pending output is dropped.
  - A term presented with clear is consumed and discarded.
  - clear has priority over every other event.

## Timing
- Reset values (async assert, rst_n low):
  - valid_out=0, result=0, batch_idx=row_idx=col_idx=0, last_out=0.
  - Internal acc=0, k_cnt=0, counters 0.
  - ready_in=1 after reset.
- Latency: final term accepted at edge t → valid_out=1 and result valid after edge t; consumer may take it in cycle t+1.
- Throughput: one term per cycle sustained when ready_out is held high; one element every K cycles.
- Backpressure: with the output full and ready_out low, non-final terms of the next element keep being accepted. Only the completing term stalls.
- Reset mid-element: partial sums are discarded; the next accepted term is k=0 of element (0,0,0).

## Test plan
- K=4, M=N=2, BATCH=2, ready_out=1, terms 1,2,3,4 repeated for 32 beats:
  - 8 results, each = 10.
  - Indices cycle (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0)…
  - last_out on the 4th and 8th results.
  - Then wrap to batch 0.
- Signed: terms 0x7FFFFFFF ×4:
  - result = 0x01FFFFFFFC (ACC_W=40).
- Signed: terms 0x80000000 ×4:
  - result = -0x200000000.
- Backpressure: hold ready_out=0 after the first result while streaming:
  - ready_in=1 for the next 3 terms, 0 on the 4th.
  - The first result is held stable.
  - Raise ready_out: the 4th term is accepted the same cycle and the second result appears next cycle.
- clear asserted after 2 terms with valid_in=1, and separately with an undrained result:
  - valid_out=0 next cycle.
  - The next 4 terms 5,5,5,5 give 20 at index (0,0,0).
- rst_n pulse low mid-element:
  - All outputs 0 immediately.
  - The following element sums only post-reset terms.
